// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: strobed serial pattern matcher with match counter, optional stop limit and window display
module seq_pattern_detector #(
  parameter int LEN = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101,
  parameter int CNT_W = 8,
  parameter bit OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [LEN-1:0]   window,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             busy
);
  localparam int FW = $clog2(LEN + 1);
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
  state_t           state_q, state_d;
  logic [LEN-1:0]   window_q, window_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             match_q, match_d, done_q, done_d;
  logic [LEN-1:0]   shifted;
  logic             sample, valid, hit;
  assign shifted = {window_q[LEN-2:0], din};
  assign sample  = en && state_q != HOLD;
  // the edge that brings in the LEN-th bit already counts as a full window
  assign valid   = state_q == RUN || (state_q == FILL && fill_q == FW'(LEN - 1));
  assign hit     = sample && valid && shifted == PATTERN;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    match_d  = 1'b0;
    done_d   = done_q;
    if (sample) begin
      window_d = shifted;
      fill_d   = state_q == FILL ? fill_q + 1'b1 : fill_q;
      state_d  = valid ? RUN : FILL;
    end
    if (hit) begin
      match_d = 1'b1;
      cnt_d   = cnt_inc;
      if (!OVERLAP) begin
        fill_d  = '0;
        state_d = FILL;
      end
      if (limit != '0 && cnt_inc >= limit) begin
        done_d  = 1'b1;
        state_d = HOLD;
      end
    end
    if (clr) begin
      state_d  = FILL;
      window_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
      match_d  = 1'b0;
      done_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      window_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end
  assign window    = window_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign busy      = state_q == RUN;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed checks of overlap, non-overlap, strobe gaps, limit/clear and saturation
module tb_seq_pattern_detector;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, din = 1'b0, clr = 1'b0;
  logic [7:0] limit = '0;
  logic [1:0] limit_s = '0;
  logic [3:0] win_o, win_n, win_s;
  logic       m_o, m_n, m_s, d_o, d_n, d_s, b_o, b_n, b_s;
  logic [7:0] c_o, c_n;
  logic [1:0] c_s;
  int         n_cmp = 0, n_mis = 0, hits;
  always #5 clk = ~clk;
  seq_pattern_detector u_ov (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .limit(limit),
    .window(win_o), .match(m_o), .match_cnt(c_o), .done(d_o), .busy(b_o)
  );
  seq_pattern_detector #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .limit(limit),
    .window(win_n), .match(m_n), .match_cnt(c_n), .done(d_n), .busy(b_n)
  );
  seq_pattern_detector #(.PATTERN(4'b1111), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .limit(limit_s),
    .window(win_s), .match(m_s), .match_cnt(c_s), .done(d_s), .busy(b_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic e, input logic d);
    en = e;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
  endtask
  initial begin
    logic [6:0]  s7;
    logic [10:0] s11;
    logic [3:0]  s4;
    do_reset();
    chk("rst_window", win_o, 4'h0);
    chk("rst_match", m_o, 0);
    chk("rst_cnt", c_o, 0);
    chk("rst_done", d_o, 0);
    chk("rst_busy", b_o, 0);
    step(1, 1); step(1, 1); step(1, 0);
    chk("basic_no_early", m_o, 0);
    chk("basic_fill_busy", b_o, 0);
    step(1, 1);
    chk("basic_match", m_o, 1);
    chk("basic_window", win_o, 4'b1101);
    chk("basic_cnt", c_o, 1);
    chk("basic_busy", b_o, 1);
    step(0, 0);
    chk("basic_pulse_end", m_o, 0);
    chk("basic_hold_win", win_o, 4'b1101);
    do_reset();
    s7 = 7'b1101101;
    for (int i = 6; i >= 0; i--) begin
      step(1, s7[i]);
      chk($sformatf("ovl_match_b%0d", 7 - i), m_o, (i == 3 || i == 0) ? 1 : 0);
    end
    chk("ovl_cnt", c_o, 2);
    chk("novl_cnt", c_n, 1);
    chk("novl_busy", b_n, 0);
    chk("novl_window", win_n, 4'b1101);
    step(1, 1);
    chk("novl_refill_match", m_n, 0);
    chk("novl_refill_busy", b_n, 1);
    do_reset();
    s4 = 4'b1101;
    hits = 0;
    for (int i = 3; i >= 0; i--) begin
      step(1, s4[i]);
      hits += int'(m_o);
      if (i == 0) chk("gap_match", m_o, 1);
      for (int g = 0; g < 3; g++) begin
        step(0, g[0] ^ ~s4[i]);
        hits += int'(m_o);
      end
    end
    chk("gap_hits", hits, 1);
    chk("gap_cnt", c_o, 1);
    chk("gap_window", win_o, 4'b1101);
    do_reset();
    limit = 8'd2;
    s11 = 11'b11011101101;
    hits = 0;
    for (int i = 10; i >= 0; i--) begin
      step(1, s11[i]);
      hits += int'(m_o);
    end
    chk("lim_hits", hits, 2);
    chk("lim_done", d_o, 1);
    chk("lim_cnt", c_o, 2);
    chk("lim_busy", b_o, 0);
    chk("lim_window", win_o, 4'b1101);
    hits = 0;
    for (int i = 3; i >= 0; i--) begin
      step(1, s4[i]);
      hits += int'(m_o);
    end
    chk("hold_hits", hits, 0);
    chk("hold_cnt", c_o, 2);
    chk("hold_done", d_o, 1);
    clr = 1'b1;
    step(1, 1);
    clr = 1'b0;
    chk("clr_window", win_o, 0);
    chk("clr_cnt", c_o, 0);
    chk("clr_done", d_o, 0);
    chk("clr_busy", b_o, 0);
    chk("clr_match", m_o, 0);
    step(1, 1); step(1, 1); step(1, 0); step(1, 1);
    chk("post_clr_match", m_o, 1);
    chk("post_clr_cnt", c_o, 1);
    limit = 8'd0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1, 1);
      chk($sformatf("sat_match_s%0d", k), m_s, k >= 4 ? 1 : 0);
      chk($sformatf("sat_cnt_s%0d", k), c_s, k < 4 ? 0 : (k - 3 > 3 ? 3 : k - 3));
    end
    chk("sat_done", d_s, 0);
    rst = 1'b1;
    step(1, 1);
    rst = 1'b0;
    chk("midrst_cnt", c_s, 0);
    chk("midrst_busy", b_s, 0);
    chk("midrst_window", win_s, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
